des_key_sched: RTL and testbench

DES_KEY_SCHED -- requirements
Module: des_key_sched

---
 rtl/des_key_sched.sv | 140 ++++++++++++++
 tb/tb_des_key_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched.sv
// DES key schedule: PC-1 capture, per-round rotation, registered PC-2 subkey; DES_KEY_SCHED_DECRYPT_EN adds reverse order.
// Latency: K1 valid two cycles after start, then one key per handshake; subkey/round hold while subkey_ready is low.
module des_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:64] key,
`ifdef DES_KEY_SCHED_DECRYPT_EN
  input  logic        decrypt,
`endif
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [1:48] subkey,
  output logic [3:0]  round,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  state_t      state;
  logic [1:28] c, d, c_nxt, d_nxt;
  logic [3:0]  round_nxt, last_round;
  logic        dec_q, hs, parity_unused;

  function automatic logic [1:56] pc1(input logic [1:64] k);
    return {k[57], k[49], k[41], k[33], k[25], k[17], k[9],  k[1],  k[58], k[50], k[42], k[34], k[26], k[18],
            k[10], k[2],  k[59], k[51], k[43], k[35], k[27], k[19], k[11], k[3],  k[60], k[52], k[44], k[36],
            k[63], k[55], k[47], k[39], k[31], k[23], k[15], k[7],  k[62], k[54], k[46], k[38], k[30], k[22],
            k[14], k[6],  k[61], k[53], k[45], k[37], k[29], k[21], k[13], k[5],  k[28], k[20], k[12], k[4]};
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    return {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],  cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
            cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],  cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
            cd[41], cd[52], cd[31], cd[37], cd[47], cd[55], cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
            cd[44], cd[49], cd[39], cd[56], cd[34], cd[53], cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] v, input logic two);
    return two ? {v[3:28], v[1:2]} : {v[2:28], v[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] v, input logic two);
    return two ? {v[27:28], v[1:26]} : {v[28], v[1:27]};
  endfunction

  // Rounds 1, 2, 9 and 16 (indices 0, 1, 8, 15) shift by one; all others by two.
  function automatic logic double_shift(input logic [3:0] r);
    return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
  endfunction

  assign parity_unused = ^{key[8], key[16], key[24], key[32], key[40], key[48], key[56], key[64]};
  assign hs            = subkey_valid & subkey_ready;
  assign last_round    = dec_q ? 4'd0 : 4'd15;

`ifdef DES_KEY_SCHED_DECRYPT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dec_q <= 1'b0;
    else if (state == IDLE && start)
      dec_q <= decrypt;
  end
`else
  assign dec_q = 1'b0;
`endif

  // Decrypt walks the schedule backwards: K16 is the unrotated PC-1 value and
  // each step undoes the rotation that produced the current round.
  always_comb begin
    c_nxt     = c;
    d_nxt     = d;
    round_nxt = round;
    if (state == LOAD) begin
      round_nxt = dec_q ? 4'd15 : 4'd0;
      if (!dec_q) begin
        c_nxt = rotl(c, 1'b0);
        d_nxt = rotl(d, 1'b0);
      end
    end else if (state == ROUND && hs && round != last_round) begin
      if (dec_q) begin
        round_nxt = round - 4'd1;
        c_nxt     = rotr(c, double_shift(round));
        d_nxt     = rotr(d, double_shift(round));
      end else begin
        round_nxt = round + 4'd1;
        c_nxt     = rotl(c, double_shift(round_nxt));
        d_nxt     = rotl(d, double_shift(round_nxt));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      subkey_valid <= 1'b0;
      done         <= 1'b0;
      round        <= 4'd0;
      subkey       <= '0;
      c            <= '0;
      d            <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          {c, d} <= pc1(key);
          busy   <= 1'b1;
          state  <= LOAD;
        end
        LOAD: begin
          c            <= c_nxt;
          d            <= d_nxt;
          round        <= round_nxt;
          subkey       <= pc2({c_nxt, d_nxt});
          subkey_valid <= 1'b1;
          state        <= ROUND;
        end
        ROUND: if (hs) begin
          if (round == last_round) begin
            subkey_valid <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end else begin
            c      <= c_nxt;
            d      <= d_nxt;
            round  <= round_nxt;
            subkey <= pc2({c_nxt, d_nxt});
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_sched.sv
// Randomized scoreboard bench for des_key_sched against a table-driven DES key schedule model.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        subkey_ready = 1'b0;
  logic [1:64] key = '0;
  logic        busy, subkey_valid, done;
  logic [1:48] subkey;
  logic [3:0]  round;
`ifdef DES_KEY_SCHED_DECRYPT_EN
  logic        decrypt = 1'b0;
`endif

  des_key_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key),
`ifdef DES_KEY_SCHED_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .busy(busy), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .subkey(subkey), .round(round), .done(done)
  );

  always #5 clk = ~clk;

  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                              10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                              14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                              23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;

  typedef struct packed { logic [47:0] sk; logic [3:0] rnd; } exp_t;
  typedef struct packed { int lat; bit exact; } done_exp_t;

  exp_t      exp_q[$];
  done_exp_t done_q[$];
  int ncmp = 0, nfail = 0, cyc = 0, start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name, input string detail);
    ncmp++;
    nfail++;
    $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  function automatic logic [27:0] rotl28(input logic [27:0] v, input int s);
    logic [63:0] w;
    w = {36'd0, v};
    w = ((w << s) | (w >> (28 - s))) & 64'h0FFF_FFFF;
    return w[27:0];
  endfunction

  // Round r uses the PC-1 halves rotated by the cumulative shift count.
  task automatic push_expected(input logic [63:0] k, input bit dec, input bit kat);
    logic [27:0] c0, d0;
    logic [55:0] cd;
    logic [47:0] ks [16];
    int tot;
    c0 = '0;
    d0 = '0;
    tot = 0;
    for (int i = 0; i < 28; i++) begin
      c0 = (c0 << 1) | 28'((k >> (64 - PC1[i])) & 64'd1);
      d0 = (d0 << 1) | 28'((k >> (64 - PC1[i + 28])) & 64'd1);
    end
    for (int r = 0; r < 16; r++) begin
      tot += SHIFTS[r];
      cd = {rotl28(c0, tot % 28), rotl28(d0, tot % 28)};
      ks[r] = '0;
      for (int j = 0; j < 48; j++)
        ks[r] = (ks[r] << 1) | 48'((cd >> (56 - PC2[j])) & 56'd1);
    end
    if (kat) begin
      ks[0]  = 48'h1B02EFFC7072;
      ks[15] = 48'hCB3D8B0E17F5;
    end
    for (int r = 0; r < 16; r++) begin
      int idx;
      idx = dec ? 15 - r : r;
      exp_q.push_back('{sk: ks[idx], rnd: 4'(idx)});
    end
  endtask

  initial begin : monitor
    logic        vld_prev, held;
    logic [47:0] held_sk;
    logic [3:0]  held_rnd;
    exp_t        e;
    done_exp_t   de;
    vld_prev = 1'b0;
    held     = 1'b0;
    held_sk  = '0;
    held_rnd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vld_prev = 1'b0;
        held     = 1'b0;
      end else begin
        if (subkey_valid && !vld_prev)
          check("first_key_latency", 64'(cyc - start_cyc), 64'd2);
        if (subkey_valid && held) begin
          check("stall_subkey", 64'(subkey), 64'(held_sk));
          check("stall_round", 64'(round), 64'(held_rnd));
        end
        if (subkey_valid && subkey_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            fail("unexpected_subkey", $sformatf("got %h with none outstanding", subkey));
          end else begin
            e = exp_q.pop_front();
            check("subkey", 64'(subkey), 64'(e.sk));
            check("round", 64'(round), 64'(e.rnd));
          end
        end else if (subkey_valid) begin
          held     = 1'b1;
          held_sk  = subkey;
          held_rnd = round;
        end else begin
          held = 1'b0;
        end
        if (done) begin
          if (done_q.size() == 0) begin
            fail("unexpected_done", "done pulse with no schedule outstanding");
          end else begin
            de = done_q.pop_front();
            if (de.exact)
              check("done_latency", 64'(cyc - start_cyc), 64'(de.lat));
            else
              check("done_min_latency", 64'(cyc - start_cyc >= de.lat), 64'd1);
            check("done_keys_left", 64'(exp_q.size()), 64'd0);
          end
        end
        vld_prev = subkey_valid;
      end
    end
  end

  // mode: 1 = ready held high, 2 = ready toggling, 3 = random ready.
  task automatic run_sched(input logic [63:0] k, input logic [63:0] mkey, input bit dec,
                           input int mode, input bit kat, input int poke_rnd, input int abort_rnd);
    bit fin, poked;
    fin   = 1'b0;
    poked = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 40 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    subkey_ready = (mode == 1);
    key          = k;
    start        = 1'b1;
`ifdef DES_KEY_SCHED_DECRYPT_EN
    decrypt = dec;
`endif
    start_cyc = cyc;
    push_expected(mkey, dec, kat);
    if (abort_rnd < 0)
      done_q.push_back('{lat: (mode == 2) ? 32 : 18, exact: (mode == 1)});
    for (int i = 0; i < 300 && !fin; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      key   = {$urandom, $urandom};
`ifdef DES_KEY_SCHED_DECRYPT_EN
      decrypt = 1'($urandom_range(0, 1));
`endif
      if (done) fin = 1'b1;
      if (mode == 2) subkey_ready = ~subkey_ready;
      else if (mode == 3) subkey_ready = 1'($urandom_range(0, 1));
      if (poke_rnd >= 0 && !poked && subkey_valid && round == 4'(poke_rnd)) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (abort_rnd >= 0 && subkey_valid && round == 4'(abort_rnd)) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(subkey_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_round", 64'(round), 64'd0);
        check("abort_subkey", 64'(subkey), 64'd0);
        exp_q.delete();
        fin = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end
    start = 1'b0;
    if (!fin) fail("schedule_timeout", "done not seen within 300 cycles");
  endtask

  initial begin
    logic [63:0] rk;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(subkey_valid), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_round", 64'(round), 64'd0);
    check("reset_subkey", 64'(subkey), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_sched(KAT_KEY, KAT_KEY, 1'b0, 1, 1'b1, -1, -1);
    run_sched(KAT_KEY, KAT_KEY, 1'b0, 2, 1'b1, -1, -1);
    run_sched(KAT_KEY, KAT_KEY, 1'b0, 1, 1'b1, 5, -1);
    run_sched(KAT_KEY, KAT_KEY, 1'b0, 1, 1'b1, -1, 7);
    run_sched(64'd0, 64'd0, 1'b0, 1, 1'b0, -1, -1);
    run_sched(KAT_KEY ^ 64'h0101010101010101, KAT_KEY, 1'b0, 1, 1'b1, -1, -1);
    for (int i = 0; i < 6; i++) begin
      rk = {$urandom, $urandom};
      run_sched(rk, rk, 1'b0, (i % 3) + 1, 1'b0, (i == 4) ? 3 : -1, -1);
    end
`ifdef DES_KEY_SCHED_DECRYPT_EN
    run_sched(KAT_KEY, KAT_KEY, 1'b1, 1, 1'b1, -1, -1);
    run_sched(KAT_KEY, KAT_KEY, 1'b1, 2, 1'b1, 10, -1);
    for (int i = 0; i < 4; i++) begin
      rk = {$urandom, $urandom};
      run_sched(rk, rk, 1'($urandom_range(0, 1)), 3, 1'b0, -1, -1);
    end
`endif

    repeat (5) @(posedge clk);
    #1;
    check("keys_outstanding", 64'(exp_q.size()), 64'd0);
    check("dones_outstanding", 64'(done_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
